// File: rtl/clock_ctrl_pkg.sv
// Shared definitions for the CPU clock controller: state encoding,
// default rate divisors and the divider counter width.
package clock_ctrl_pkg;

  localparam int unsigned CNT_W = 24;
  localparam int unsigned TICK_CNT_W = 16;

  localparam int unsigned DEF_RATE0_DIV = 13_500_000;
  localparam int unsigned DEF_RATE1_DIV = 2_700_000;
  localparam int unsigned DEF_RATE2_DIV = 27_000;
  localparam int unsigned DEF_RATE3_DIV = 1;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 270_000;

  typedef enum logic [1:0] {
    ST_HALTED     = 2'd0,
    ST_RUN        = 2'd1,
    ST_STEP       = 2'd2,
    ST_CPU_HALTED = 2'd3
  } clk_state_e;

endpackage

// File: rtl/step_debouncer.sv
// Synchronizes and debounces the raw step button, emitting a one-cycle
// pulse on each accepted rising edge of the debounced level.
module step_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 270_000
) (
  input  logic clock_in,
  input  logic reset_n,
  input  logic button_in,
  output logic pulse_out
);

  localparam int unsigned STABLE_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(DEBOUNCE_CYCLES - 1);

  logic                sync_meta;
  logic                sync_q;
  logic                level_q;
  logic                level_prev_q;
  logic [STABLE_W-1:0] stable_cnt;

  // Level only moves after DEBOUNCE_CYCLES consecutive differing samples;
  // a sample matching the current level restarts the count.
  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      sync_meta    <= 1'b0;
      sync_q       <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      stable_cnt   <= '0;
      pulse_out    <= 1'b0;
    end else begin
      sync_meta    <= button_in;
      sync_q       <= sync_meta;
      level_prev_q <= level_q;
      pulse_out    <= level_q & ~level_prev_q;
      if (sync_q == level_q) begin
        stable_cnt <= '0;
      end else if (stable_cnt == STABLE_LAST) begin
        level_q    <= sync_q;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + STABLE_W'(1);
      end
    end
  end

endmodule

// File: rtl/cpu_clock_controller.sv
// CPU execution clock sequencer: halt / single-step / free-run at four
// rates, producing a one-cycle clock enable plus an LED toggle.
module cpu_clock_controller
  import clock_ctrl_pkg::*;
#(
  parameter int unsigned RATE0_DIV       = DEF_RATE0_DIV,
  parameter int unsigned RATE1_DIV       = DEF_RATE1_DIV,
  parameter int unsigned RATE2_DIV       = DEF_RATE2_DIV,
  parameter int unsigned RATE3_DIV       = DEF_RATE3_DIV,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic                  clock_in,
  input  logic                  reset_n,
  input  logic                  run_in,
  input  logic                  step_in,
  input  logic [1:0]            rate_select_in,
  input  logic                  halt_in,
  output logic                  tick_out,
  output logic                  clock_out,
  output logic [1:0]            state_out,
  output logic [TICK_CNT_W-1:0] tick_count_out
);

  logic             run_meta;
  logic             run_sync;
  logic             step_pulse;
  clk_state_e       state_q;
  clk_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_eff;
  logic [CNT_W-1:0] div_last;
  logic [1:0]       rate_q;
  logic             rate_changed;
  logic             tick_d;

  step_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_debouncer (
    .clock_in (clock_in),
    .reset_n  (reset_n),
    .button_in(step_in),
    .pulse_out(step_pulse)
  );

  // Terminal count for the currently selected rate.
  always_comb begin
    div_last = CNT_W'(RATE0_DIV - 1);
    unique case (rate_select_in)
      2'd0: div_last = CNT_W'(RATE0_DIV - 1);
      2'd1: div_last = CNT_W'(RATE1_DIV - 1);
      2'd2: div_last = CNT_W'(RATE2_DIV - 1);
      2'd3: div_last = CNT_W'(RATE3_DIV - 1);
      default: div_last = CNT_W'(RATE0_DIV - 1);
    endcase
  end

  // A rate change makes this cycle count as position zero of the new period.
  assign rate_changed = (rate_select_in != rate_q);
  assign cnt_eff      = rate_changed ? '0 : cnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    tick_d  = 1'b0;
    unique case (state_q)
      ST_HALTED: begin
        if (halt_in) begin
          state_d = ST_CPU_HALTED;
        end else if (run_sync) begin
          state_d = ST_RUN;
        end else if (step_pulse) begin
          state_d = ST_STEP;
          tick_d  = 1'b1;
        end
      end
      ST_RUN: begin
        if (halt_in) begin
          state_d = ST_CPU_HALTED;
        end else if (!run_sync) begin
          state_d = ST_HALTED;
        end else if (cnt_eff == div_last) begin
          tick_d = 1'b1;
        end else begin
          cnt_d = cnt_eff + CNT_W'(1);
        end
      end
      ST_STEP: begin
        state_d = ST_HALTED;
      end
      ST_CPU_HALTED: begin
        if (!run_sync && !halt_in) begin
          state_d = ST_HALTED;
        end
      end
      default: begin
        state_d = ST_HALTED;
      end
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      run_meta       <= 1'b0;
      run_sync       <= 1'b0;
      state_q        <= ST_HALTED;
      cnt_q          <= '0;
      rate_q         <= 2'd0;
      tick_out       <= 1'b0;
      clock_out      <= 1'b0;
      tick_count_out <= '0;
    end else begin
      run_meta <= run_in;
      run_sync <= run_meta;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rate_q   <= rate_select_in;
      tick_out <= tick_d;
      if (tick_d) begin
        clock_out      <= ~clock_out;
        tick_count_out <= tick_count_out + TICK_CNT_W'(1);
      end
    end
  end

  assign state_out = 2'(state_q);

endmodule
